// File: rtl/axi_lite_ipif_single_bar.sv
// AXI4-Lite slave to IPIF bridge for one address range (BAR0).
// Runs one transaction at a time; reads take priority over writes.
module axi_lite_ipif_single_bar #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_USE_WSTRB        = 0,
    parameter int C_DPHASE_TIMEOUT   = 8,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BAR0_BASEADDR = 32'hFFFFFFFF,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BAR0_HIGHADDR = 32'h00000000
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            Bus2IP_Clk,
    output logic                            Bus2IP_Resetn,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   Bus2IP_Addr,
    output logic                            Bus2IP_CS,
    output logic                            Bus2IP_RNW,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   Bus2IP_Data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] Bus2IP_BE,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   IP2Bus_Data,
    input  logic                            IP2Bus_RdAck,
    input  logic                            IP2Bus_WrAck,
    input  logic                            IP2Bus_Error
);
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int BW = C_S_AXI_DATA_WIDTH / 8;
    localparam int TW = (C_DPHASE_TIMEOUT > 1) ? $clog2(C_DPHASE_TIMEOUT) : 1;
    localparam logic [AW-1:0] MASK = C_BAR0_HIGHADDR ^ C_BAR0_BASEADDR;

    typedef enum logic [2:0] {IDLE, RD_ACC, WR_ACC, RD_RESP, WR_RESP} state_t;

    state_t          state_reg, state_next;
    logic            arready_reg, arready_next;
    logic            awready_reg, awready_next;
    logic            wready_reg, wready_next;
    logic            rvalid_reg, rvalid_next;
    logic            bvalid_reg, bvalid_next;
    logic [1:0]      rresp_reg, rresp_next;
    logic [1:0]      bresp_reg, bresp_next;
    logic [DW-1:0]   rdata_reg, rdata_next;
    logic            cs_reg, cs_next;
    logic            rnw_reg, rnw_next;
    logic [AW-1:0]   addr_reg, addr_next;
    logic [DW-1:0]   data_reg, data_next;
    logic [BW-1:0]   be_reg, be_next;
    logic [TW-1:0]   cnt_reg, cnt_next;

    logic ar_hit, aw_hit, timeout_hit;

    assign ar_hit = (S_AXI_ARADDR & ~MASK) == (C_BAR0_BASEADDR & ~MASK);
    assign aw_hit = (S_AXI_AWADDR & ~MASK) == (C_BAR0_BASEADDR & ~MASK);
    // cnt_reg holds the number of CS cycles already spent without an ack
    assign timeout_hit = (C_DPHASE_TIMEOUT > 0) && (cnt_reg == TW'(C_DPHASE_TIMEOUT - 1));

    always_comb begin
        state_next   = state_reg;
        arready_next = 1'b0;
        awready_next = 1'b0;
        wready_next  = 1'b0;
        rvalid_next  = rvalid_reg;
        bvalid_next  = bvalid_reg;
        rresp_next   = rresp_reg;
        bresp_next   = bresp_reg;
        rdata_next   = rdata_reg;
        cs_next      = cs_reg;
        rnw_next     = rnw_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        be_next      = be_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (S_AXI_ARVALID) begin
                    state_next   = RD_ACC;
                    arready_next = 1'b1;
                    addr_next    = S_AXI_ARADDR & MASK;
                    cs_next      = ar_hit;
                    rnw_next     = 1'b1;
                    be_next      = '1;
                    cnt_next     = '0;
                end else if (S_AXI_AWVALID && S_AXI_WVALID) begin
                    state_next   = WR_ACC;
                    awready_next = 1'b1;
                    wready_next  = 1'b1;
                    addr_next    = S_AXI_AWADDR & MASK;
                    data_next    = S_AXI_WDATA;
                    be_next      = (C_USE_WSTRB != 0) ? S_AXI_WSTRB : '1;
                    cs_next      = aw_hit;
                    rnw_next     = 1'b0;
                    cnt_next     = '0;
                end
            end
            RD_ACC: begin
                // CS low in an access state means the address missed BAR0
                if (!cs_reg) begin
                    rvalid_next = 1'b1;
                    rresp_next  = 2'b11;
                    rdata_next  = '0;
                    state_next  = RD_RESP;
                end else if (IP2Bus_RdAck) begin
                    rvalid_next = 1'b1;
                    rresp_next  = IP2Bus_Error ? 2'b10 : 2'b00;
                    rdata_next  = IP2Bus_Data;
                    cs_next     = 1'b0;
                    state_next  = RD_RESP;
                end else if (timeout_hit) begin
                    rvalid_next = 1'b1;
                    rresp_next  = 2'b10;
                    rdata_next  = '0;
                    cs_next     = 1'b0;
                    state_next  = RD_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            WR_ACC: begin
                if (!cs_reg) begin
                    bvalid_next = 1'b1;
                    bresp_next  = 2'b11;
                    state_next  = WR_RESP;
                end else if (IP2Bus_WrAck) begin
                    bvalid_next = 1'b1;
                    bresp_next  = IP2Bus_Error ? 2'b10 : 2'b00;
                    cs_next     = 1'b0;
                    state_next  = WR_RESP;
                end else if (timeout_hit) begin
                    bvalid_next = 1'b1;
                    bresp_next  = 2'b10;
                    cs_next     = 1'b0;
                    state_next  = WR_RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RD_RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            WR_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_reg   <= IDLE;
            arready_reg <= 1'b0;
            awready_reg <= 1'b0;
            wready_reg  <= 1'b0;
            rvalid_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            rresp_reg   <= 2'b00;
            bresp_reg   <= 2'b00;
            rdata_reg   <= '0;
            cs_reg      <= 1'b0;
            rnw_reg     <= 1'b1;
            addr_reg    <= '0;
            data_reg    <= '0;
            be_reg      <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            arready_reg <= arready_next;
            awready_reg <= awready_next;
            wready_reg  <= wready_next;
            rvalid_reg  <= rvalid_next;
            bvalid_reg  <= bvalid_next;
            rresp_reg   <= rresp_next;
            bresp_reg   <= bresp_next;
            rdata_reg   <= rdata_next;
            cs_reg      <= cs_next;
            rnw_reg     <= rnw_next;
            addr_reg    <= addr_next;
            data_reg    <= data_next;
            be_reg      <= be_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign S_AXI_ARREADY = arready_reg;
    assign S_AXI_AWREADY = awready_reg;
    assign S_AXI_WREADY  = wready_reg;
    assign S_AXI_RVALID  = rvalid_reg;
    assign S_AXI_RRESP   = rresp_reg;
    assign S_AXI_RDATA   = rdata_reg;
    assign S_AXI_BVALID  = bvalid_reg;
    assign S_AXI_BRESP   = bresp_reg;
    assign Bus2IP_Clk    = S_AXI_ACLK;
    assign Bus2IP_Resetn = S_AXI_ARESETN;
    assign Bus2IP_Addr   = addr_reg;
    assign Bus2IP_CS     = cs_reg;
    assign Bus2IP_RNW    = rnw_reg;
    assign Bus2IP_Data   = data_reg;
    assign Bus2IP_BE     = be_reg;
endmodule

// File: tb/tb_axi_lite_ipif_single_bar.sv
// Self-checking bench for axi_lite_ipif_single_bar: AXI master tasks, an IPIF
// peripheral model with programmable ack latency, and a response scoreboard.
module tb_axi_lite_ipif_single_bar;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] HIGH = 32'h8000_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        ip_clk, ip_resetn, cs, rnw;
    logic [31:0] ip_addr, ip_wdata;
    logic [3:0]  be;
    logic [31:0] ip_rdata = '0;
    logic        rdack = 1'b0, wrack = 1'b0, ip_err = 1'b0;

    always #5 clk = ~clk;

    axi_lite_ipif_single_bar #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(32), .C_USE_WSTRB(1),
        .C_DPHASE_TIMEOUT(8), .C_BAR0_BASEADDR(BASE), .C_BAR0_HIGHADDR(HIGH)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .Bus2IP_Clk(ip_clk), .Bus2IP_Resetn(ip_resetn), .Bus2IP_Addr(ip_addr),
        .Bus2IP_CS(cs), .Bus2IP_RNW(rnw), .Bus2IP_Data(ip_wdata), .Bus2IP_BE(be),
        .IP2Bus_Data(ip_rdata), .IP2Bus_RdAck(rdack), .IP2Bus_WrAck(wrack), .IP2Bus_Error(ip_err)
    );

    // Peripheral model: raises its ack on CS cycle ack_at (0 = never) and holds it while CS=1
    int ack_at = 3;
    int cs_cnt = 0;
    always @(posedge clk) begin
        if (!rst_n || !cs) begin
            cs_cnt <= 0;
            rdack  <= 1'b0;
            wrack  <= 1'b0;
        end else begin
            cs_cnt <= cs_cnt + 1;
            if (ack_at >= 2 && cs_cnt == ack_at - 2) begin
                if (rnw) rdack <= 1'b1;
                else     wrack <= 1'b1;
            end
        end
    end

    // Monitor: running counts of observed pulses/beats plus a capture of the IPIF request
    int cs_n = 0, arr_n = 0, awr_n = 0, wr_n = 0, both_n = 0, rbeat_n = 0, bval_n = 0;
    logic [31:0] cap_addr = '0, cap_data = '0;
    logic [3:0]  cap_be = '0;
    logic        cap_rnw = 1'b0;
    always @(negedge clk) begin
        if (cs) begin
            cs_n     <= cs_n + 1;
            cap_addr <= ip_addr;
            cap_data <= ip_wdata;
            cap_be   <= be;
            cap_rnw  <= rnw;
        end
        if (arready)            arr_n   <= arr_n + 1;
        if (awready)            awr_n   <= awr_n + 1;
        if (wready)             wr_n    <= wr_n + 1;
        if (awready && wready)  both_n  <= both_n + 1;
        if (rvalid && rready)   rbeat_n <= rbeat_n + 1;
        if (bvalid)             bval_n  <= bval_n + 1;
    end

    int n_checks = 0, n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    typedef struct {
        bit          is_rd;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    task automatic check_resp(input string tag, input bit is_rd, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        check_eq({tag, "_sb_pending"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check_eq({tag, "_kind"}, 32'(is_rd), 32'(e.is_rd));
        check_eq({tag, "_resp"}, 32'(resp), 32'(e.resp));
        if (e.is_rd) check_eq({tag, "_rdata"}, data, e.data);
        $display("%s: %s resp=%b data=0x%08h", tag, is_rd ? "read" : "write", resp, data);
    endtask

    // Waits (bounded) for 0:arready 1:awready 2:rvalid 3:bvalid at a falling edge
    task automatic wait_for(input int which, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            case (which)
                0: seen = arready;
                1: seen = awready;
                2: seen = rvalid;
                default: seen = bvalid;
            endcase
        end
        check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
        sb.push_back('{1'b1, exp_data, exp_resp});
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1;
        wait_for(0, {tag, "_arready"});
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        wait_for(2, {tag, "_rvalid"});
        check_resp(tag, 1'b1, rdata, rresp);
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp, input int bdelay);
        bit held = 1'b1;
        sb.push_back('{1'b0, 32'h0, exp_resp});
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb; awvalid = 1'b1; wvalid = 1'b1;
        wait_for(1, {tag, "_awready"});
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for(3, {tag, "_bvalid"});
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            held &= bvalid;
        end
        check_eq({tag, "_bvalid_held"}, 32'(held), 32'd1);
        check_resp(tag, 1'b0, 32'h0, bresp);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check_eq({tag, "_bvalid_clear"}, 32'(bvalid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int s_cs, s_beat, s_aw, s_w, s_both, s_ar, s_bv;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_cs", 32'(cs), 0);
        check_eq("rst_rnw", 32'(rnw), 1);
        check_eq("rst_ready", {29'b0, arready, awready, wready}, 0);
        check_eq("rst_valid", {30'b0, rvalid, bvalid}, 0);
        check_eq("rst_addr", ip_addr, 0);
        check_eq("rst_be", 32'(be), 0);
        check_eq("rst_passthru", {30'b0, ip_clk, ip_resetn}, {30'b0, clk, 1'b0});
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Read hit: ack on 3rd CS cycle, held while CS=1
        ack_at = 3; ip_rdata = 32'hDEADBEEF;
        s_cs = cs_n; s_beat = rbeat_n;
        do_read("rd_hit", 32'h8000_0008, 32'hDEADBEEF, 2'b00);
        check_eq("rd_hit_addr", cap_addr, 32'h8);
        check_eq("rd_hit_rnw", 32'(cap_rnw), 1);
        check_eq("rd_hit_be", 32'(cap_be), 32'hF);
        check_eq("rd_hit_cs_cycles", 32'(cs_n - s_cs), 3);
        check_eq("rd_hit_beats", 32'(rbeat_n - s_beat), 1);

        // Write with strobes, BREADY held low 5 cycles
        ack_at = 2;
        s_cs = cs_n; s_aw = awr_n; s_w = wr_n; s_both = both_n;
        do_write("wr_strb", 32'h8000_0004, 32'h12345678, 4'h3, 2'b00, 5);
        check_eq("wr_strb_aw_pulses", 32'(awr_n - s_aw), 1);
        check_eq("wr_strb_w_pulses", 32'(wr_n - s_w), 1);
        check_eq("wr_strb_same_cycle", 32'(both_n - s_both), 1);
        check_eq("wr_strb_addr", cap_addr, 32'h4);
        check_eq("wr_strb_data", cap_data, 32'h12345678);
        check_eq("wr_strb_be", 32'(cap_be), 32'h3);
        check_eq("wr_strb_rnw", 32'(cap_rnw), 0);
        check_eq("wr_strb_cs_cycles", 32'(cs_n - s_cs), 2);

        // Simultaneous read and write: read must complete first
        ack_at = 3; ip_rdata = 32'hCAFEF00D;
        sb.push_back('{1'b1, 32'hCAFEF00D, 2'b00});
        sb.push_back('{1'b0, 32'h0, 2'b00});
        s_aw = awr_n;
        @(posedge clk); #1;
        araddr = 32'h8000_0010; awaddr = 32'h8000_0020; wdata = 32'hA5A55A5A; wstrb = 4'hF;
        arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
        wait_for(0, "sim_arready");
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        wait_for(2, "sim_rvalid");
        check_resp("sim_rd", 1'b1, rdata, rresp);
        check_eq("sim_no_aw_before_r", 32'(awr_n - s_aw), 0);
        @(posedge clk); #1;
        rready = 1'b0;
        wait_for(1, "sim_awready");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        wait_for(3, "sim_bvalid");
        check_resp("sim_wr", 1'b0, 32'h0, bresp);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        check_eq("sim_wr_addr", cap_addr, 32'h20);
        check_eq("sim_wr_data", cap_data, 32'hA5A55A5A);

        // Decode miss
        ip_rdata = 32'h11111111;
        s_cs = cs_n;
        do_read("rd_miss", 32'h9000_0000, 32'h0, 2'b11);
        check_eq("rd_miss_cs_cycles", 32'(cs_n - s_cs), 0);

        // IP error on read and on write
        ack_at = 2; ip_err = 1'b1; ip_rdata = 32'h0BADF00D;
        do_read("rd_err", 32'h8000_0040, 32'h0BADF00D, 2'b10);
        do_write("wr_err", 32'h8000_0044, 32'h55AA55AA, 4'hF, 2'b10, 0);
        ip_err = 1'b0;

        // Timeout with no ack
        ack_at = 0;
        s_cs = cs_n;
        do_read("rd_tmo", 32'h8000_0100, 32'h0, 2'b10);
        check_eq("rd_tmo_cs_cycles", 32'(cs_n - s_cs), 8);
        s_cs = cs_n;
        do_write("wr_tmo", 32'h8000_0104, 32'h0, 4'hF, 2'b10, 1);
        check_eq("wr_tmo_cs_cycles", 32'(cs_n - s_cs), 8);

        // Reset in the middle of an access
        @(posedge clk); #1;
        araddr = 32'h8000_0200; arvalid = 1'b1;
        wait_for(0, "rst_mid_arready");
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_cs_before", 32'(cs), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_cs", 32'(cs), 0);
        check_eq("rst_mid_ready_valid", {27'b0, arready, awready, wready, rvalid, bvalid}, 0);
        check_eq("rst_mid_rnw", 32'(rnw), 1);
        check_eq("rst_mid_addr", ip_addr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_ar = arr_n; s_aw = awr_n; s_cs = cs_n; s_bv = bval_n; s_beat = rbeat_n;
        rready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rready = 1'b0;
        check_eq("rst_mid_quiet", 32'((arr_n - s_ar) + (awr_n - s_aw) + (cs_n - s_cs) + (bval_n - s_bv) + (rbeat_n - s_beat)), 0);

        // Back to normal operation after reset
        ack_at = 3; ip_rdata = 32'h600DF00D;
        do_read("rd_after_rst", 32'h8000_FFFC, 32'h600DF00D, 2'b00);
        check_eq("rd_after_rst_addr", cap_addr, 32'hFFFC);
        check_eq("sb_drained", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
